// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
package pipe_ctrl_pkg;

    localparam int unsigned DefaultAddrW = 64;
    localparam int unsigned DefaultRegAw = 5;
    localparam int unsigned BubCntW      = 3;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StLuStall  = 2'd1,
        StRedirect = 2'd2,
        StMemWait  = 2'd3
    } hazard_state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic redirect;
    } stage_ctrl_t;

    localparam stage_ctrl_t CtrlIdle     = '0;
    localparam stage_ctrl_t CtrlStallAll = '{pc_stall: 1'b1, if_id_stall: 1'b1,
                                             id_ex_stall: 1'b1, ex_mem_stall: 1'b1,
                                             default: 1'b0};
    localparam stage_ctrl_t CtrlLuBubble = '{pc_stall: 1'b1, if_id_stall: 1'b1,
                                             id_ex_flush: 1'b1, default: 1'b0};
    localparam stage_ctrl_t CtrlFlushAll = '{if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                             default: 1'b0};
    localparam stage_ctrl_t CtrlRedirect = '{if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                             redirect: 1'b1, default: 1'b0};

    // Counter preload so that a follow-on state lasts exactly 'cycles' cycles (count down to 0).
    function automatic logic [BubCntW-1:0] bub_preload(int unsigned cycles);
        logic [BubCntW-1:0] val;
        val = '0;
        if (cycles > 0) begin
            val = BubCntW'(cycles - 1);
        end
        return val;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the EX load destination and ID sources.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = DefaultRegAw
) (
    input  logic [REG_AW-1:0] id_rs1_addr_i,
    input  logic [REG_AW-1:0] id_rs2_addr_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic              ex_rd_we_i,
    input  logic              ex_is_load_i,
    output logic              lu_hit_o
);

    logic rs1_match;
    logic rs2_match;
    logic ex_load_writes;

    // x0 is hardwired to zero, so a load into it can never create a dependency.
    assign ex_load_writes = ex_is_load_i & ex_rd_we_i & (ex_rd_addr_i != '0);
    assign rs1_match      = id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i);
    assign rs2_match      = id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i);
    assign lu_hit_o       = ex_load_writes & (rs1_match | rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall, flush and PC-redirect sequencing around ID/EX.
// Define PIPE_HAZ_PERF_EN to add the stall/flush cycle counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W           = DefaultAddrW,
    parameter int unsigned REG_AW           = DefaultRegAw,
    parameter int unsigned LOAD_USE_BUBBLES = 1,
    parameter int unsigned REDIRECT_BUBBLES = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [REG_AW-1:0] IdRs1Addr,
    input  logic [REG_AW-1:0] IdRs2Addr,
    input  logic              IdRs1Used,
    input  logic              IdRs2Used,
    input  logic [REG_AW-1:0] ExRdAddr,
    input  logic              ExRdWriteEnable,
    input  logic              ExIsLoad,
    input  logic              ExBranchTaken,
    input  logic [ADDR_W-1:0] ExBranchTarget,
    input  logic              MemReq,
    input  logic              MemReady,
    output logic              PcStall,
    output logic              IfIdStall,
    output logic              IfIdFlush,
    output logic              IdExStall,
    output logic              IdExFlush,
    output logic              ExMemStall,
    output logic              Redirect,
    output logic [ADDR_W-1:0] RedirectPc
`ifdef PIPE_HAZ_PERF_EN
    ,
    output logic [31:0]       PerfStallCnt,
    output logic [31:0]       PerfFlushCnt
`endif
);

    // The first load-use bubble is issued from StRun, so StLuStall covers the remainder.
    localparam logic [BubCntW-1:0] LuPreload = bub_preload(LOAD_USE_BUBBLES - 1);
    localparam logic [BubCntW-1:0] RdPreload = bub_preload(REDIRECT_BUBBLES);

    hazard_state_e      state_q, state_d;
    logic [BubCntW-1:0] bub_cnt_q, bub_cnt_d;
    logic               resume_lu_q, resume_lu_d;
    logic               lu_hit;
    logic               mem_wait;
    stage_ctrl_t        ctrl;
    stage_ctrl_t        ctrl_out;

    load_use_detect #(
        .REG_AW(REG_AW)
    ) u_load_use_detect (
        .id_rs1_addr_i(IdRs1Addr),
        .id_rs2_addr_i(IdRs2Addr),
        .id_rs1_used_i(IdRs1Used),
        .id_rs2_used_i(IdRs2Used),
        .ex_rd_addr_i (ExRdAddr),
        .ex_rd_we_i   (ExRdWriteEnable),
        .ex_is_load_i (ExIsLoad),
        .lu_hit_o     (lu_hit)
    );

    assign mem_wait = MemReq & ~MemReady;

    always_comb begin
        state_d     = state_q;
        bub_cnt_d   = bub_cnt_q;
        resume_lu_d = resume_lu_q;
        ctrl        = CtrlIdle;

        unique case (state_q)
            StRun: begin
                if (mem_wait) begin
                    ctrl        = CtrlStallAll;
                    state_d     = StMemWait;
                    resume_lu_d = 1'b0;
                end else if (ExBranchTaken) begin
                    ctrl = CtrlRedirect;
                    if (REDIRECT_BUBBLES > 0) begin
                        state_d   = StRedirect;
                        bub_cnt_d = RdPreload;
                    end
                end else if (lu_hit) begin
                    ctrl = CtrlLuBubble;
                    if (LOAD_USE_BUBBLES > 1) begin
                        state_d   = StLuStall;
                        bub_cnt_d = LuPreload;
                    end
                end
            end

            StLuStall: begin
                // A memory wait freezes the bubble sequence; the count survives untouched.
                if (mem_wait) begin
                    ctrl        = CtrlStallAll;
                    state_d     = StMemWait;
                    resume_lu_d = 1'b1;
                end else begin
                    ctrl = CtrlLuBubble;
                    if (bub_cnt_q == '0) begin
                        state_d = StRun;
                    end else begin
                        bub_cnt_d = bub_cnt_q - BubCntW'(1);
                    end
                end
            end

            StRedirect: begin
                // EX already holds a bubble here, so any branch indication is stale.
                ctrl = CtrlFlushAll;
                if (bub_cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    bub_cnt_d = bub_cnt_q - BubCntW'(1);
                end
            end

            StMemWait: begin
                if (mem_wait) begin
                    ctrl = CtrlStallAll;
                end else begin
                    state_d = resume_lu_q ? StLuStall : StRun;
                end
            end

            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= StRun;
            bub_cnt_q   <= '0;
            resume_lu_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bub_cnt_q   <= bub_cnt_d;
            resume_lu_q <= resume_lu_d;
        end
    end

    // Outputs stay quiet during reset; a flush on a register overrides a hold on it.
    always_comb begin
        ctrl_out = CtrlIdle;
        if (Rst) begin
            ctrl_out             = ctrl;
            ctrl_out.if_id_stall = ctrl.if_id_stall & ~ctrl.if_id_flush;
            ctrl_out.id_ex_stall = ctrl.id_ex_stall & ~ctrl.id_ex_flush;
        end
    end

    assign PcStall    = ctrl_out.pc_stall;
    assign IfIdStall  = ctrl_out.if_id_stall;
    assign IfIdFlush  = ctrl_out.if_id_flush;
    assign IdExStall  = ctrl_out.id_ex_stall;
    assign IdExFlush  = ctrl_out.id_ex_flush;
    assign ExMemStall = ctrl_out.ex_mem_stall;
    assign Redirect   = ctrl_out.redirect;
    assign RedirectPc = ctrl_out.redirect ? ExBranchTarget : '0;

`ifdef PIPE_HAZ_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, ctrl_out.pc_stall};
        perf_flush_d = perf_flush_q + {31'd0, ctrl_out.id_ex_flush};
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign PerfStallCnt = perf_stall_q;
    assign PerfFlushCnt = perf_flush_q;
`endif

endmodule
